// File: rtl/dmem_lsu_pkg.sv
// -----------------------------------------------------------------------------
// dmem_lsu_pkg
// Shared types and constants for the data-memory LSU port.
//   state_e   : port FSM states (IDLE, RESP, MERGE)
//   BE_FULL   : byte-enable pattern of a full-word store
//   BE_NONE   : byte-enable pattern of an empty store
//   LANE_W    : width of one byte lane
//   NUM_LANES : byte lanes per data word
// -----------------------------------------------------------------------------
package dmem_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESP  = 2'd1,
        ST_MERGE = 2'd2
    } state_e;

    localparam logic [3:0] BE_FULL   = 4'b1111;
    localparam logic [3:0] BE_NONE   = 4'b0000;
    localparam int         LANE_W    = 8;
    localparam int         NUM_LANES = 4;

endpackage

// File: rtl/dmem_byte_merge.sv
// -----------------------------------------------------------------------------
// dmem_byte_merge
// Combinational byte-lane merge for read-modify-write stores.
// Ports:
//   i_old_word : word currently held in RAM
//   i_new_word : lane-aligned store data
//   i_be       : byte enables, 1 = take lane from i_new_word
//   o_merged   : merged word to write back
// -----------------------------------------------------------------------------
module dmem_byte_merge
    import dmem_lsu_pkg::*;
(
    input  logic [LANE_W*NUM_LANES-1:0] i_old_word,
    input  logic [LANE_W*NUM_LANES-1:0] i_new_word,
    input  logic [NUM_LANES-1:0]        i_be,
    output logic [LANE_W*NUM_LANES-1:0] o_merged
);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign o_merged[g*LANE_W +: LANE_W] = i_be[g] ? i_new_word[g*LANE_W +: LANE_W]
                                                      : i_old_word[g*LANE_W +: LANE_W];
    end

endmodule

// File: rtl/dmem_lsu_port.sv
// -----------------------------------------------------------------------------
// dmem_lsu_port
// Initiator side of the data-memory port. Converts OBI-style core requests
// into accesses on a single-port, word-wide RAM with a registered read and no
// byte enables; sub-word stores are done as read-modify-write.
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   data_req_i / data_gnt_o      : request handshake (grant is combinational)
//   data_we_i, data_be_i         : store flag and byte enables
//   data_addr_i, data_wdata_i    : byte address and lane-aligned store data
//   data_rvalid_o, data_rdata_o  : response valid and load data
//   data_err_o                   : access error (only with the address check)
//   mem_en_o, mem_wr_o           : RAM enable / write
//   mem_addr_o, mem_wdata_o      : RAM word address / write data
//   mem_rdata_i                  : RAM read data, one cycle after enable
// Configuration:
//   DMEM_ADDR_CHECK_EN : when defined, requests with nonzero address bits
//                        above the RAM range get an error response and make
//                        no RAM access. When undefined, those bits alias.
// -----------------------------------------------------------------------------
module dmem_lsu_port
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic                  data_rvalid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  data_err_o,
    output logic                  mem_en_o,
    output logic                  mem_wr_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    state_e                r_state;
    logic                  r_rvalid;
    logic                  r_is_load;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_be;
    logic [DATA_WIDTH-1:0] r_wdata;

    state_e                w_state_nxt;
    logic                  w_rvalid_nxt;
    logic                  w_is_load_nxt;
    logic                  w_err_nxt;
    logic                  w_capture;
    logic                  w_gnt;
    logic                  w_mem_en;
    logic                  w_mem_wr;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [ADDR_WIDTH-1:0] w_word_addr;
    logic                  w_addr_bad;
    logic                  w_unused_bits;

    assign w_word_addr = data_addr_i[ADDR_WIDTH+1:2];

`ifdef DMEM_ADDR_CHECK_EN
    assign w_addr_bad    = |data_addr_i[31:ADDR_WIDTH+2];
    assign w_unused_bits = ^data_addr_i[1:0];
`else
    // Upper address bits are ignored, so out-of-range addresses alias.
    assign w_addr_bad    = 1'b0;
    assign w_unused_bits = ^{data_addr_i[31:ADDR_WIDTH+2], data_addr_i[1:0]};
`endif

    dmem_byte_merge u_merge (
        .i_old_word (mem_rdata_i),
        .i_new_word (r_wdata),
        .i_be       (r_be),
        .o_merged   (w_merged)
    );

    // Next-state, grant and RAM command decode.
    always_comb begin
        w_state_nxt   = ST_IDLE;
        w_rvalid_nxt  = 1'b0;
        w_is_load_nxt = 1'b0;
        w_err_nxt     = 1'b0;
        w_capture     = 1'b0;
        w_gnt         = 1'b0;
        w_mem_en      = 1'b0;
        w_mem_wr      = 1'b0;
        w_mem_addr    = w_word_addr;
        w_mem_wdata   = data_wdata_i;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                // No grant while in reset: the request would be dropped
                // without a response.
                if (data_req_i && !rst_i) begin
                    w_gnt        = 1'b1;
                    w_state_nxt  = ST_RESP;
                    w_rvalid_nxt = 1'b1;
                    if (w_addr_bad) begin
                        w_err_nxt = 1'b1;
                    end else if (!data_we_i) begin
                        w_mem_en      = 1'b1;
                        w_is_load_nxt = 1'b1;
                    end else if (data_be_i == BE_FULL) begin
                        w_mem_en = 1'b1;
                        w_mem_wr = 1'b1;
                    end else if (data_be_i != BE_NONE) begin
                        // Partial store: read old word now, write merged next.
                        w_mem_en     = 1'b1;
                        w_capture    = 1'b1;
                        w_rvalid_nxt = 1'b0;
                        w_state_nxt  = ST_MERGE;
                    end else begin
                        // Empty store: respond without touching the RAM.
                        w_mem_en = 1'b0;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MERGE: begin
                // A reset arriving here must not commit the pending write.
                w_mem_en     = !rst_i;
                w_mem_wr     = !rst_i;
                w_mem_addr   = r_addr;
                w_mem_wdata  = w_merged;
                w_state_nxt  = ST_RESP;
                w_rvalid_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Load responses take the RAM output directly; stores return zero;
    // with no response the last value is held.
    always_comb begin
        w_rdata = r_rdata;
        if (r_rvalid) begin
            w_rdata = r_is_load ? mem_rdata_i : {DATA_WIDTH{1'b0}};
        end else begin
            w_rdata = r_rdata;
        end
    end

    // State, response and pending partial-store registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_rvalid  <= 1'b0;
            r_is_load <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= {DATA_WIDTH{1'b0}};
            r_addr    <= {ADDR_WIDTH{1'b0}};
            r_be      <= 4'b0000;
            r_wdata   <= {DATA_WIDTH{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_is_load <= w_is_load_nxt;
            r_err     <= w_err_nxt;
            r_rdata   <= w_rdata;
            if (w_capture) begin
                r_addr  <= w_word_addr;
                r_be    <= data_be_i;
                r_wdata <= data_wdata_i;
            end else begin
                r_addr  <= r_addr;
                r_be    <= r_be;
                r_wdata <= r_wdata;
            end
        end
    end

    assign data_gnt_o    = w_gnt;
    assign data_rvalid_o = r_rvalid;
    assign data_rdata_o  = w_rdata;
    assign data_err_o    = r_err;
    assign mem_en_o      = w_mem_en;
    assign mem_wr_o      = w_mem_wr;
    assign mem_addr_o    = w_mem_addr;
    assign mem_wdata_o   = w_mem_wdata;

endmodule

// File: tb/tb_dmem_lsu_port.sv
module tb_dmem_lsu_port;

    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        gnt;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        mem_en;
    logic        mem_wr;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Bench RAM model plus a preload path.
    logic [31:0] mem [0:(1<<AW)-1];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [31:0]   pl_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_lsu_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .data_req_i   (req),
        .data_gnt_o   (gnt),
        .data_we_i    (we),
        .data_be_i    (be),
        .data_addr_i  (addr),
        .data_wdata_i (wdata),
        .data_rvalid_o(rvalid),
        .data_rdata_o (rdata),
        .data_err_o   (err),
        .mem_en_o     (mem_en),
        .mem_wr_o     (mem_wr),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    // Registered-read RAM returning the pre-write word.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (mem_en) begin
            mem_rdata <= mem[mem_addr];
            if (mem_wr) mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; be = 4'b0000;
        addr = 32'h0; wdata = 32'h0; pl_en = 1'b0; pl_addr = '0; pl_data = 32'h0;
        tick();
        preload(8'd0, 32'hA0A0_A0A0);
        preload(8'd1, 32'hA1A1_A1A1);
        preload(8'd2, 32'h1122_3344);
        preload(8'd3, 32'hDEAD_BEEF);
        preload(8'd4, 32'h4444_4444);
        preload(8'd5, 32'h5566_7788);
        preload(8'd6, 32'h0000_0000);
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_gnt", {31'd0, gnt}, 32'd0);

        // Load latency: word 3 via byte address 0x0C
        req = 1'b1; we = 1'b0; addr = 32'h0000_000C; #1;
        check("ld_gnt", {31'd0, gnt}, 32'd1);
        check("ld_mem_en", {31'd0, mem_en}, 32'd1);
        check("ld_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("ld_mem_addr", {24'd0, mem_addr}, 32'd3);
        tick(); req = 1'b0;
        check("ld_rvalid", {31'd0, rvalid}, 32'd1);
        check("ld_rdata", rdata, 32'hDEAD_BEEF);
        check("ld_err", {31'd0, err}, 32'd0);
        tick();
        check("ld_rvalid_drop", {31'd0, rvalid}, 32'd0);
        check("ld_rdata_hold", rdata, 32'hDEAD_BEEF);

        // Back-to-back loads of words 0,1,2
        req = 1'b1; we = 1'b0; addr = 32'h0; #1;
        check("b2b_gnt0", {31'd0, gnt}, 32'd1);
        tick(); addr = 32'h4; #1;
        check("b2b_gnt1", {31'd0, gnt}, 32'd1);
        check("b2b_rv0", {31'd0, rvalid}, 32'd1);
        check("b2b_rd0", rdata, 32'hA0A0_A0A0);
        tick(); addr = 32'h8; #1;
        check("b2b_gnt2", {31'd0, gnt}, 32'd1);
        check("b2b_rv1", {31'd0, rvalid}, 32'd1);
        check("b2b_rd1", rdata, 32'hA1A1_A1A1);
        tick(); req = 1'b0;
        check("b2b_rv2", {31'd0, rvalid}, 32'd1);
        check("b2b_rd2", rdata, 32'h1122_3344);
        tick();
        check("b2b_idle", {31'd0, rvalid}, 32'd0);

        // Partial store be=0100 to word 2, then a load held on req
        req = 1'b1; we = 1'b1; be = 4'b0100; addr = 32'h8; wdata = 32'h00AA_0000; #1;
        check("ps_gnt_c0", {31'd0, gnt}, 32'd1);
        check("ps_rd_c0", {30'd0, mem_en, mem_wr}, 32'd2);
        tick();
        we = 1'b0; be = 4'b0000; wdata = 32'h0; #1;
        check("ps_gnt_c1", {31'd0, gnt}, 32'd0);
        check("ps_wr_c1", {30'd0, mem_en, mem_wr}, 32'd3);
        check("ps_addr_c1", {24'd0, mem_addr}, 32'd2);
        check("ps_wdata_c1", mem_wdata, 32'h11AA_3344);
        check("ps_rv_c1", {31'd0, rvalid}, 32'd0);
        tick();
        check("ps_rv_c2", {31'd0, rvalid}, 32'd1);
        check("ps_rd_c2", rdata, 32'h0);
        check("ps_ldgnt_c2", {31'd0, gnt}, 32'd1);
        tick(); req = 1'b0;
        check("ps_ld_rv", {31'd0, rvalid}, 32'd1);
        check("ps_ld_rdata", rdata, 32'h11AA_3344);
        check("ps_mem2", mem[2], 32'h11AA_3344);
        tick();

        // Empty store to word 4
        req = 1'b1; we = 1'b1; be = 4'b0000; addr = 32'h10; wdata = 32'hFFFF_FFFF; #1;
        check("be0_gnt", {31'd0, gnt}, 32'd1);
        check("be0_mem_en", {31'd0, mem_en}, 32'd0);
        tick(); req = 1'b0;
        check("be0_rv", {31'd0, rvalid}, 32'd1);
        check("be0_rdata", rdata, 32'h0);
        check("be0_mem4", mem[4], 32'h4444_4444);
        tick();

        // Full store to word 6
        req = 1'b1; we = 1'b1; be = 4'b1111; addr = 32'h18; wdata = 32'hCAFE_F00D; #1;
        check("fs_cmd", {30'd0, mem_en, mem_wr}, 32'd3);
        check("fs_wdata", mem_wdata, 32'hCAFE_F00D);
        tick(); req = 1'b0;
        check("fs_rv", {31'd0, rvalid}, 32'd1);
        check("fs_mem6", mem[6], 32'hCAFE_F00D);
        tick();

        // Reset during MERGE of a be=0001 store to word 5
        req = 1'b1; we = 1'b1; be = 4'b0001; addr = 32'h14; wdata = 32'h0000_00EE; #1;
        check("rm_gnt", {31'd0, gnt}, 32'd1);
        tick(); req = 1'b0; rst = 1'b1; #1;
        check("rm_no_wr", {30'd0, mem_en, mem_wr}, 32'd0);
        tick(); rst = 1'b0;
        check("rm_rv", {31'd0, rvalid}, 32'd0);
        check("rm_mem5", mem[5], 32'h5566_7788);
        req = 1'b1; we = 1'b0; be = 4'b0000; addr = 32'h14; #1;
        check("rm_ld_gnt", {31'd0, gnt}, 32'd1);
        tick(); req = 1'b0;
        check("rm_ld_rdata", rdata, 32'h5566_7788);
        tick();

        // Out-of-range load at 0x400
        req = 1'b1; we = 1'b0; addr = 32'h0000_0400; #1;
        check("oor_gnt", {31'd0, gnt}, 32'd1);
`ifdef DMEM_ADDR_CHECK_EN
        check("oor_mem_en", {31'd0, mem_en}, 32'd0);
        tick(); req = 1'b0;
        check("oor_rv", {31'd0, rvalid}, 32'd1);
        check("oor_err", {31'd0, err}, 32'd1);
        check("oor_rdata", rdata, 32'h0);
`else
        check("oor_mem_en", {31'd0, mem_en}, 32'd1);
        check("oor_mem_addr", {24'd0, mem_addr}, 32'd0);
        tick(); req = 1'b0;
        check("oor_rv", {31'd0, rvalid}, 32'd1);
        check("oor_err", {31'd0, err}, 32'd0);
        check("oor_rdata", rdata, 32'hA0A0_A0A0);
`endif
        tick();
        check("end_err", {31'd0, err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
